dram_xfer_ctrl: RTL and testbench

Link-side DRAM transfer engine that sits directly outside the eyeriss top on link_clk and serves its DRAM port. It answers forward transfers (start_forward, re_from_dram, returning rdata_from_dram/valid_from_dram) and backward transfers (start_backward, we_to_dram/wdata_to_dram) against a single-port word memory. It tracks one address cursor per transfer type and signals transfer_done at the end of each transfer. It replaces the behavioural DRAM in the system bench and is the block the chip-level wrapper instantiates.

---
 rtl/shared_pkg.sv | 30 +++
 rtl/dram_xfer_ctrl_if.sv | 24 ++
 rtl/dram_xfer_ctrl_cursor_bank.sv | 52 +++++
 rtl/dram_xfer_ctrl.sv | 134 +++++++++++++
 tb/tb_dram_xfer_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shared_pkg.sv
//==============================================================================
// Module      : shared_pkg
// Description : Shared types and constants for the link-side DRAM transfer engine.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package shared_pkg;

    localparam int DRAM_ADDR_WIDTH = 20;
    localparam int WORDS_WIDTH     = 16;

    typedef enum logic [1:0] {
        IFMAP  = 2'd0,
        FILTER = 2'd1,
        BIAS   = 2'd2,
        PSUM   = 2'd3
    } xfer_type_e;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FWD       = 3'd1,
        S_FWD_DRAIN = 3'd2,
        S_BWD       = 3'd3,
        S_DONE      = 3'd4
    } xfer_state_e;

endpackage

`default_nettype wire

// File: rtl/dram_xfer_ctrl_if.sv
//==============================================================================
// Module      : dram_xfer_ctrl_if
// Description : Single-port word-memory bus between the transfer engine and DRAM.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface dram_xfer_ctrl_if #(
    parameter int ADDR_WIDTH = shared_pkg::DRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_re;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata;

    modport master (output mem_addr, output mem_re, output mem_we,
                    output mem_wdata, input mem_rdata);
    modport slave  (input mem_addr, input mem_re, input mem_we,
                    input mem_wdata, output mem_rdata);
endinterface

`default_nettype wire

// File: rtl/dram_xfer_ctrl_cursor_bank.sv
//==============================================================================
// Module      : xfer_cursor_bank
// Description : Per-type base and address-cursor registers with load/rewind/increment.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module xfer_cursor_bank #(
    parameter int NUM_TYPES  = 4,
    parameter int ADDR_WIDTH = 20,
    parameter int TYPE_WIDTH = 2
) (
    input  wire logic                                 link_clk,
    input  wire logic                                 reset,
    input  wire logic                                 load,
    input  wire logic [TYPE_WIDTH-1:0]                load_sel,
    input  wire logic [ADDR_WIDTH-1:0]                load_data,
    input  wire logic                                 rewind,
    input  wire logic                                 inc,
    input  wire logic [TYPE_WIDTH-1:0]                inc_sel,
    output logic      [NUM_TYPES-1:0][ADDR_WIDTH-1:0] cursors
);

    localparam logic [ADDR_WIDTH-1:0] c_one_addr = ADDR_WIDTH'(1);

    generate
        for (genvar i = 0; i < NUM_TYPES; i++) begin : g_type
            logic [ADDR_WIDTH-1:0] r_base;
            logic [ADDR_WIDTH-1:0] r_cursor;

            // A load on this index beats a simultaneous rewind.
            always_ff @(posedge link_clk or negedge reset) begin
                if (!reset) begin
                    r_base   <= '0;
                    r_cursor <= '0;
                end else if (load && (load_sel == TYPE_WIDTH'(i))) begin
                    r_base   <= load_data;
                    r_cursor <= load_data;
                end else if (rewind) begin
                    r_cursor <= r_base;
                end else if (inc && (inc_sel == TYPE_WIDTH'(i))) begin
                    r_cursor <= r_cursor + c_one_addr;
                end
            end

            assign cursors[i] = r_cursor;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/dram_xfer_ctrl.sv
//==============================================================================
// Module      : dram_xfer_ctrl
// Description : Link-side DRAM transfer engine serving forward and backward transfers.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dram_xfer_ctrl #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = shared_pkg::DRAM_ADDR_WIDTH,
    parameter int WORDS_WIDTH = shared_pkg::WORDS_WIDTH,
    parameter int NUM_TYPES   = 4,
    parameter int TYPE_WIDTH  = $clog2(NUM_TYPES)
) (
    input  wire logic                   link_clk,
    input  wire logic                   reset,
    input  wire logic                   start_forward,
    input  wire logic                   start_backward,
    input  wire logic [WORDS_WIDTH-1:0] words_num,
    input  wire logic [TYPE_WIDTH-1:0]  transfer_type,
    input  wire logic                   re_from_dram,
    output logic      [DATA_WIDTH-1:0]  rdata_from_dram,
    output logic                        valid_from_dram,
    input  wire logic                   we_to_dram,
    input  wire logic [DATA_WIDTH-1:0]  wdata_to_dram,
    output logic                        transfer_done,
    input  wire logic                   base_we,
    input  wire logic [TYPE_WIDTH-1:0]  base_sel,
    input  wire logic [ADDR_WIDTH-1:0]  base_wdata,
    input  wire logic                   rewind,
    dram_xfer_ctrl_if.master            mem,
    output logic                        busy,
    output logic                        proto_err
);

    import shared_pkg::*;

    localparam logic [WORDS_WIDTH-1:0] c_one_word = WORDS_WIDTH'(1);

    xfer_state_e                          r_state;
    logic [TYPE_WIDTH-1:0]                r_type;
    logic [WORDS_WIDTH-1:0]               r_remaining;
    logic                                 r_valid;
    logic                                 r_proto_err;
    logic [NUM_TYPES-1:0][ADDR_WIDTH-1:0] w_cursors;
    logic [ADDR_WIDTH-1:0]                w_cursor;
    logic                                 w_idle;
    logic                                 w_rd_issue;
    logic                                 w_wr_issue;
    logic                                 w_last;

    assign w_idle     = (r_state == S_IDLE);
    assign w_cursor   = w_cursors[r_type];
    assign w_rd_issue = (r_state == S_FWD) && re_from_dram && (r_remaining != '0);
    assign w_wr_issue = (r_state == S_BWD) && we_to_dram && (r_remaining != '0);
    assign w_last     = (r_remaining == c_one_word);

    xfer_cursor_bank #(
        .NUM_TYPES  (NUM_TYPES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .TYPE_WIDTH (TYPE_WIDTH)
    ) u_cursor_bank (
        .link_clk  (link_clk),
        .reset     (reset),
        .load      (base_we && w_idle),
        .load_sel  (base_sel),
        .load_data (base_wdata),
        .rewind    (rewind && w_idle),
        .inc       (w_rd_issue || w_wr_issue),
        .inc_sel   (r_type),
        .cursors   (w_cursors)
    );

    always_ff @(posedge link_clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_type      <= '0;
            r_remaining <= '0;
            r_valid     <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_valid <= w_rd_issue;
            if (!w_idle && (start_forward || start_backward || base_we || rewind))
                r_proto_err <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (start_forward) begin
                        r_type      <= transfer_type;
                        r_remaining <= words_num;
                        r_state     <= (words_num == '0) ? S_DONE : S_FWD;
                        if (start_backward)
                            r_proto_err <= 1'b1;
                    end else if (start_backward) begin
                        r_type      <= transfer_type;
                        r_remaining <= words_num;
                        r_state     <= (words_num == '0) ? S_DONE : S_BWD;
                    end
                end
                S_FWD: begin
                    if (w_rd_issue) begin
                        r_remaining <= r_remaining - c_one_word;
                        if (w_last)
                            r_state <= S_FWD_DRAIN;
                    end
                end
                // Last read's data is on the bus this cycle.
                S_FWD_DRAIN: r_state <= S_DONE;
                S_BWD: begin
                    if (w_wr_issue) begin
                        r_remaining <= r_remaining - c_one_word;
                        if (w_last)
                            r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy            = !w_idle;
    assign proto_err       = r_proto_err;
    assign transfer_done   = (r_state == S_DONE);
    assign valid_from_dram = r_valid;
    assign rdata_from_dram = r_valid ? mem.mem_rdata : '0;

    assign mem.mem_re    = w_rd_issue;
    assign mem.mem_we    = w_wr_issue;
    assign mem.mem_addr  = (w_rd_issue || w_wr_issue) ? w_cursor : '0;
    assign mem.mem_wdata = w_wr_issue ? wdata_to_dram : '0;

endmodule

`default_nettype wire

// File: tb/tb_dram_xfer_ctrl.sv
//==============================================================================
// Module      : tb_dram_xfer_ctrl
// Description : Directed self-checking bench for dram_xfer_ctrl with a word-memory model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dram_xfer_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_forward, start_backward;
    logic [15:0] words_num;
    logic [1:0]  transfer_type;
    logic        re_from_dram, we_to_dram;
    logic [15:0] wdata_to_dram;
    logic [15:0] rdata_from_dram;
    logic        valid_from_dram, transfer_done;
    logic        base_we, rewind;
    logic [1:0]  base_sel;
    logic [19:0] base_wdata;
    logic        busy, proto_err;

    logic        pl_we;
    logic [19:0] pl_addr;
    logic [15:0] pl_data;
    bit   [15:0] mem_arr [0:(1<<20)-1];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    dram_xfer_ctrl_if #(.ADDR_WIDTH(20), .DATA_WIDTH(16)) bus ();

    dram_xfer_ctrl dut (
        .link_clk        (clk),
        .reset           (reset),
        .start_forward   (start_forward),
        .start_backward  (start_backward),
        .words_num       (words_num),
        .transfer_type   (transfer_type),
        .re_from_dram    (re_from_dram),
        .rdata_from_dram (rdata_from_dram),
        .valid_from_dram (valid_from_dram),
        .we_to_dram      (we_to_dram),
        .wdata_to_dram   (wdata_to_dram),
        .transfer_done   (transfer_done),
        .base_we         (base_we),
        .base_sel        (base_sel),
        .base_wdata      (base_wdata),
        .rewind          (rewind),
        .mem             (bus),
        .busy            (busy),
        .proto_err       (proto_err)
    );

    // Synchronous-read word memory; preload port used only while the DUT is quiet.
    always @(posedge clk) begin
        if (bus.mem_re)
            bus.mem_rdata <= mem_arr[bus.mem_addr];
        if (pl_we)
            mem_arr[pl_addr] <= pl_data;
        else if (bus.mem_we)
            mem_arr[bus.mem_addr] <= bus.mem_wdata;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [19:0] a, input logic [15:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        step();
        pl_we = 1'b0;
    endtask

    task automatic start_fwd(input logic [1:0] t, input logic [15:0] n);
        start_forward = 1'b1; transfer_type = t; words_num = n;
        step();
        start_forward = 1'b0;
    endtask

    task automatic load_base(input logic [1:0] s, input logic [19:0] v);
        base_we = 1'b1; base_sel = s; base_wdata = v;
        step();
        base_we = 1'b0;
    endtask

    initial begin
        logic [15:0] t1_data [4];
        logic [15:0] t2_data [3];
        int          t2_pat  [5];
        int          t3_pat  [3];
        logic [15:0] t3_data [3];
        int          nrd;
        int          prev_re;

        t1_data = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
        t2_data = '{16'h1111, 16'h2222, 16'h3333};
        t2_pat  = '{1, 0, 1, 0, 1};
        t3_pat  = '{1, 0, 1};
        t3_data = '{16'h0005, 16'h0000, 16'h0007};

        reset = 1'b0;
        start_forward = 0; start_backward = 0; words_num = 0; transfer_type = 0;
        re_from_dram = 0; we_to_dram = 0; wdata_to_dram = 0;
        base_we = 0; base_sel = 0; base_wdata = 0; rewind = 0;
        pl_we = 0; pl_addr = 0; pl_data = 0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_valid", valid_from_dram, 0);
        check("rst_rdata", rdata_from_dram, 0);
        check("rst_done", transfer_done, 0);
        check("rst_perr", proto_err, 0);
        check("rst_mem_re", bus.mem_re, 0);
        check("rst_mem_we", bus.mem_we, 0);

        for (int i = 0; i < 4; i++) preload(20'h100 + 20'(i), t1_data[i]);
        for (int i = 0; i < 3; i++) preload(20'h104 + 20'(i), t2_data[i]);
        preload(20'h107, 16'h4444);
        preload(20'hFFFFF, 16'h5555);
        preload(20'h00000, 16'h6666);
        preload(20'h300, 16'h7000);
        preload(20'h301, 16'h7001);
        reset = 1'b1;
        step();

        // Test 1: four-word forward burst with re held high
        load_base(2'd0, 20'h100);
        start_fwd(2'd0, 16'd4);
        re_from_dram = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t1_mem_re", bus.mem_re, 1);
            check("t1_addr", bus.mem_addr, 32'h100 + k);
            check("t1_valid", valid_from_dram, (k > 0) ? 1 : 0);
            if (k > 0) check("t1_rdata", rdata_from_dram, t1_data[k-1]);
            step();
        end
        #1;
        check("t1_drain_valid", valid_from_dram, 1);
        check("t1_drain_rdata", rdata_from_dram, 16'hDDDD);
        check("t1_drain_no_re", bus.mem_re, 0);
        check("t1_drain_done", transfer_done, 0);
        step();
        re_from_dram = 1'b0;
        #1;
        check("t1_done", transfer_done, 1);
        check("t1_done_valid", valid_from_dram, 0);
        step();
        check("t1_done_clear", transfer_done, 0);
        check("t1_idle", busy, 0);

        // Test 2: re toggling, cursor continues at 0x104
        start_fwd(2'd0, 16'd3);
        nrd = 0; prev_re = 0;
        for (int j = 0; j < 5; j++) begin
            re_from_dram = t2_pat[j][0];
            #1;
            check("t2_mem_re", bus.mem_re, t2_pat[j]);
            if (t2_pat[j] == 1) check("t2_addr", bus.mem_addr, 32'h104 + nrd);
            check("t2_valid", valid_from_dram, prev_re);
            if (prev_re == 1) check("t2_rdata", rdata_from_dram, t2_data[nrd-1]);
            check("t2_no_done", transfer_done, 0);
            if (t2_pat[j] == 1) nrd++;
            prev_re = t2_pat[j];
            step();
        end
        re_from_dram = 1'b0;
        #1;
        check("t2_drain_rdata", rdata_from_dram, 16'h3333);
        step();
        check("t2_done", transfer_done, 1);
        step();
        check("t2_done_once", transfer_done, 0);

        // Test 3: backward write with a gap
        load_base(2'd3, 20'h200);
        start_backward = 1'b1; transfer_type = 2'd3; words_num = 16'd2;
        step();
        start_backward = 1'b0;
        nrd = 0;
        for (int j = 0; j < 3; j++) begin
            we_to_dram = t3_pat[j][0];
            wdata_to_dram = t3_data[j];
            #1;
            check("t3_mem_we", bus.mem_we, t3_pat[j]);
            check("t3_no_re", bus.mem_re, 0);
            if (t3_pat[j] == 1) begin
                check("t3_addr", bus.mem_addr, 32'h200 + nrd);
                check("t3_wdata", bus.mem_wdata, t3_data[j]);
                nrd++;
            end
            check("t3_no_done", transfer_done, 0);
            step();
        end
        we_to_dram = 1'b0;
        #1;
        check("t3_done", transfer_done, 1);
        check("t3_mem200", mem_arr[20'h200], 16'h0005);
        check("t3_mem201", mem_arr[20'h201], 16'h0007);
        check("t3_perr_clean", proto_err, 0);
        step();

        // Test 4: simultaneous starts, start while busy, zero-length transfer
        start_forward = 1'b1; start_backward = 1'b1; transfer_type = 2'd0; words_num = 16'd1;
        step();
        start_forward = 1'b0; start_backward = 1'b0;
        check("t4_perr", proto_err, 1);
        check("t4_busy", busy, 1);
        start_backward = 1'b1; we_to_dram = 1'b1;
        #1;
        check("t4_bwd_ignored", bus.mem_we, 0);
        step();
        start_backward = 1'b0; we_to_dram = 1'b0;
        re_from_dram = 1'b1;
        #1;
        check("t4_mem_re", bus.mem_re, 1);
        check("t4_addr", bus.mem_addr, 32'h107);
        step();
        re_from_dram = 1'b0;
        #1;
        check("t4_rdata", rdata_from_dram, 16'h4444);
        step();
        check("t4_done", transfer_done, 1);
        step();
        start_fwd(2'd0, 16'd0);
        re_from_dram = 1'b1; we_to_dram = 1'b1;
        #1;
        check("t4_zero_done", transfer_done, 1);
        check("t4_zero_no_re", bus.mem_re, 0);
        check("t4_zero_no_we", bus.mem_we, 0);
        step();
        re_from_dram = 1'b0; we_to_dram = 1'b0;
        check("t4_zero_idle", busy, 0);
        check("t4_perr_sticky", proto_err, 1);

        // Test 5: address wrap on type 1; rewind restores type 0 in the same cycle
        rewind = 1'b1;
        load_base(2'd1, 20'hFFFFF);
        rewind = 1'b0;
        start_fwd(2'd1, 16'd2);
        re_from_dram = 1'b1;
        #1;
        check("t5_addr_top", bus.mem_addr, 32'hFFFFF);
        step();
        check("t5_addr_wrap", bus.mem_addr, 32'h00000);
        check("t5_rdata0", rdata_from_dram, 16'h5555);
        step();
        re_from_dram = 1'b0;
        #1;
        check("t5_rdata1", rdata_from_dram, 16'h6666);
        step();
        check("t5_done", transfer_done, 1);
        step();
        start_fwd(2'd0, 16'd1);
        re_from_dram = 1'b1;
        #1;
        check("t5_rewind_addr", bus.mem_addr, 32'h100);
        step();
        re_from_dram = 1'b0;
        #1;
        check("t5_rewind_rdata", rdata_from_dram, 16'hAAAA);
        step();
        step();

        // Test 6: reset mid-transfer, then a clean transfer
        load_base(2'd2, 20'h300);
        start_fwd(2'd2, 16'd5);
        re_from_dram = 1'b1;
        step();
        step();
        check("t6_pre_rdata", rdata_from_dram, 16'h7001);
        reset = 1'b0;
        #1;
        check("t6_rst_valid", valid_from_dram, 0);
        check("t6_rst_rdata", rdata_from_dram, 0);
        check("t6_rst_mem_re", bus.mem_re, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_perr", proto_err, 0);
        step();
        check("t6_rst_no_done", transfer_done, 0);
        reset = 1'b1; re_from_dram = 1'b0;
        step();
        check("t6_post_busy", busy, 0);
        check("t6_post_no_done", transfer_done, 0);
        start_fwd(2'd2, 16'd1);
        re_from_dram = 1'b1; start_backward = 1'b1; base_we = 1'b1; base_wdata = 20'h999;
        #1;
        check("t6_addr_zero", bus.mem_addr, 32'h0);
        check("t6_mem_re", bus.mem_re, 1);
        step();
        re_from_dram = 1'b0; start_backward = 1'b0; base_we = 1'b0;
        #1;
        check("t6_busy_perr", proto_err, 1);
        check("t6_rdata", rdata_from_dram, 16'h6666);
        step();
        check("t6_done", transfer_done, 1);
        step();
        check("t6_final_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
